// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX path and the upcoming RX path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_t;

    typedef logic [2:0] uart_tx_state_t;

    localparam uart_tx_state_t ST_IDLE   = 3'd0;
    localparam uart_tx_state_t ST_START  = 3'd1;
    localparam uart_tx_state_t ST_DATA   = 3'd2;
    localparam uart_tx_state_t ST_PARITY = 3'd3;
    localparam uart_tx_state_t ST_STOP   = 3'd4;

    localparam int UART_MIN_DIV = 2;

    // Register encoding 3 is reserved and behaves as no parity.
    function automatic uart_parity_t decode_parity(input logic [1:0] code);
        case (code)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock FIFO with occupancy output; shared by the UART TX and RX paths.
// Read data is the head word, combinationally visible; wr_rdy is simply !full.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_vld,
    output logic                       wr_rdy,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer separates full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_rdy = !full;
    assign rd_vld = !empty;
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_rdy && rd_vld;
    assign rd_dat = mem[rd_ptr[AW-1:0]];
    assign level  = LW'(wr_ptr - rd_ptr);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed framer with runtime divisor, parity and stop-bit count.
// txd falls 2 cycles after a push into an idle, empty block; tx_ready drops only when the FIFO is full.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_W        = 16
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [DIV_W-1:0]                cfg_div,
    input  logic [1:0]                      cfg_parity,
    input  logic                            cfg_stop2,
    input  logic                            cfg_tx_en,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    input  logic [PAYLOAD_BITS-1:0]         tx_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            uart_txd,
    output logic                            uart_tx_busy,
    output logic                            clk_req
);
    localparam int BIT_W = $clog2(PAYLOAD_BITS);

    uart_tx_state_t          state;
    logic [DIV_W-1:0]        cyc_cnt;
    logic [DIV_W-1:0]        div_q;
    uart_parity_t            par_q;
    logic                    stop2_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic                    par_bit_q;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    txd_q;
    logic                    txd_nxt;

    logic [PAYLOAD_BITS-1:0] head_dat;
    logic                    fifo_nempty;
    logic                    pop;
    logic                    bit_end;
    logic                    last_stop;
    logic [DIV_W-1:0]        div_eff;

    uart_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_vld (tx_valid),
        .wr_rdy (tx_ready),
        .wr_dat (tx_data),
        .rd_vld (fifo_nempty),
        .rd_rdy (pop),
        .rd_dat (head_dat),
        .level  (fifo_level)
    );

    assign div_eff   = (cfg_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : cfg_div;
    assign bit_end   = (cyc_cnt == div_q - DIV_W'(1));
    assign last_stop = (state == ST_STOP) && bit_end && (bit_cnt == BIT_W'(stop2_q));
    // Popping on the final stop-bit boundary chains frames with no idle gap.
    assign pop       = fifo_nempty && cfg_tx_en && ((state == ST_IDLE) || last_stop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cyc_cnt   <= '0;
            div_q     <= DIV_W'(UART_MIN_DIV);
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            bit_cnt   <= '0;
        end else if (pop) begin
            state     <= ST_START;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            div_q     <= div_eff;
            par_q     <= decode_parity(cfg_parity);
            stop2_q   <= cfg_stop2;
            shift_q   <= head_dat;
            par_bit_q <= (^head_dat) ^ (decode_parity(cfg_parity) == PAR_ODD);
        end else if (state != ST_IDLE) begin
            if (!bit_end) begin
                cyc_cnt <= cyc_cnt + DIV_W'(1);
            end else begin
                cyc_cnt <= '0;
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == BIT_W'(PAYLOAD_BITS-1)) begin
                            bit_cnt <= '0;
                            state   <= (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        state   <= ST_STOP;
                        bit_cnt <= '0;
                    end
                    ST_STOP: begin
                        if (bit_cnt == BIT_W'(stop2_q)) begin
                            state <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        txd_nxt = 1'b1;
        case (state)
            ST_START:  txd_nxt = 1'b0;
            ST_DATA:   txd_nxt = shift_q[0];
            ST_PARITY: txd_nxt = par_bit_q;
            default:   txd_nxt = 1'b1;
        endcase
    end

    // Registered pad driver: txd trails the FSM state by one cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            txd_q <= 1'b1;
        end else begin
            txd_q <= txd_nxt;
        end
    end

    assign uart_txd     = txd_q;
    assign uart_tx_busy = (state != ST_IDLE);
    assign clk_req      = uart_tx_busy || fifo_nempty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a waveform-queue reference model.
module tb_uart_tx_buffered;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        cfg_tx_en;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [2:0]  fifo_level;
    logic        uart_txd;
    logic        uart_tx_busy;
    logic        clk_req;

    int checks = 0;
    int errors = 0;
    int tn = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .PAYLOAD_BITS (8),
        .FIFO_DEPTH   (DEPTH),
        .DIV_W        (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cfg_div      (cfg_div),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .cfg_tx_en    (cfg_tx_en),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .fifo_level   (fifo_level),
        .uart_txd     (uart_txd),
        .uart_tx_busy (uart_tx_busy),
        .clk_req      (clk_req)
    );

    // Reference model: queued words, remaining busy cycles of the current
    // frame, and the future txd waveform (one entry per clock edge).
    logic [7:0] mq[$];
    logic       wave[$];
    int         rem = 0;
    logic       m_txd = 1'b1;

    always @(posedge clk) begin : model
        bit         do_push;
        bit         can_pop;
        logic [7:0] w;
        int         d;
        int         nb;
        if (!resetn) begin
            mq.delete();
            wave.delete();
            rem   = 0;
            m_txd = 1'b1;
        end else begin
            do_push = tx_valid && (mq.size() < DEPTH);
            m_txd   = (wave.size() > 0) ? wave.pop_front() : 1'b1;
            can_pop = (rem <= 1) && (mq.size() != 0) && cfg_tx_en;
            if (rem > 0) rem--;
            if (can_pop) begin
                w  = mq.pop_front();
                d  = (cfg_div < 2) ? 2 : int'(cfg_div);
                nb = 0;
                for (int c = 0; c < d; c++) wave.push_back(1'b0);
                nb++;
                for (int i = 0; i < 8; i++) begin
                    for (int c = 0; c < d; c++) wave.push_back(w[i]);
                    nb++;
                end
                if (cfg_parity == 2'd1 || cfg_parity == 2'd2) begin
                    for (int c = 0; c < d; c++) wave.push_back((^w) ^ (cfg_parity == 2'd2));
                    nb++;
                end
                for (int s = 0; s < (cfg_stop2 ? 2 : 1); s++) begin
                    for (int c = 0; c < d; c++) wave.push_back(1'b1);
                    nb++;
                end
                rem = nb * d;
            end
            if (do_push) mq.push_back(tx_data);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_txd",     32'(uart_txd),     32'(m_txd));
            check("model_busy",    32'(uart_tx_busy), 32'(rem > 0));
            check("model_level",   32'(fifo_level),   32'(mq.size()));
            check("model_ready",   32'(tx_ready),     32'(mq.size() < DEPTH));
            check("model_clk_req", 32'(clk_req),      32'((rem > 0) || (mq.size() != 0)));
        end
    end

    task automatic goto(input int target);
        repeat (target - tn) @(negedge clk);
        tn = target;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((clk_req !== 1'b0 || uart_txd !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout at %0t: clk_req=%0b txd=%0b expected 0/1", $time, clk_req, uart_txd);
        end
        @(negedge clk);
    endtask

    // Push one word into an idle block and pin each bit level and the frame length.
    task automatic send_pin(input logic [7:0] d, input logic [15:0] div, input int dd,
                            input logic [1:0] par, input logic st2, input logic [11:0] exp,
                            input int nbits, input string nm);
        int len;
        wait_idle();
        cfg_div = div; cfg_parity = par; cfg_stop2 = st2; cfg_tx_en = 1'b1;
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tn  = 0;
        len = nbits * dd;
        goto(1);
        check({nm, "_pre_start"}, 32'(uart_txd), 32'd1);
        for (int k = 0; k < nbits; k++) begin
            goto(2 + dd * k);
            check($sformatf("%s_bit%0d", nm, k), 32'(uart_txd), 32'(exp[k]));
        end
        goto(len);
        check({nm, "_busy_last"}, 32'(uart_tx_busy), 32'd1);
        goto(len + 1);
        check({nm, "_busy_end"}, 32'(uart_tx_busy), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; tx_valid = 1'b0; tx_data = '0;
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0; cfg_tx_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_txd",   32'(uart_txd),     32'd1);
        check("rst_busy",  32'(uart_tx_busy), 32'd0);
        check("rst_level", 32'(fifo_level),   32'd0);
        check("rst_ready", 32'(tx_ready),     32'd1);
        check("rst_clkreq",32'(clk_req),      32'd0);
        chk_en = 1'b1;
        resetn = 1'b1;
        @(negedge clk);

        // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit
        send_pin(8'hA5, 16'd4, 4, 2'd0, 1'b0, 12'b0000_1101_0010_10 >> 0, 10, "t1_none");
        send_pin(8'hA5, 16'd4, 4, 2'd1, 1'b0, 12'b0101_0100_1010, 11, "t2_even");
        send_pin(8'hA5, 16'd4, 4, 2'd2, 1'b0, 12'b0111_0100_1010, 11, "t2_odd");

        // Disabled transmitter fills to full, then drains after enable.
        wait_idle();
        cfg_tx_en = 1'b0; cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'h10 + 8'(i); tx_valid = 1'b1;
            @(negedge clk);
        end
        check("t3_level_full", 32'(fifo_level), 32'd4);
        check("t3_ready_full", 32'(tx_ready),   32'd0);
        @(negedge clk);
        check("t3_level_hold", 32'(fifo_level), 32'd4);
        cfg_tx_en = 1'b1;
        @(negedge clk);
        check("t3_level_pop",  32'(fifo_level), 32'd3);
        check("t3_ready_pop",  32'(tx_ready),   32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("t3_level_5th",  32'(fifo_level), 32'd4);
        check("t3_busy",       32'(uart_tx_busy), 32'd1);

        // Back-to-back frames, D=3, two stop bits.
        wait_idle();
        cfg_div = 16'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b1;
        tx_data = 8'h01; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h80;
        @(negedge clk);
        tx_valid = 1'b0;
        tn = 1;
        check("t4_level_pushpop", 32'(fifo_level), 32'd1);
        goto(34);
        check("t4_last_stop", 32'(uart_txd), 32'd1);
        goto(35);
        check("t4_start2",    32'(uart_txd), 32'd0);
        goto(66);
        check("t4_busy_last", 32'(uart_tx_busy), 32'd1);
        goto(67);
        check("t4_busy_end",  32'(uart_tx_busy), 32'd0);

        // Reset in the middle of DATA with two words queued.
        wait_idle();
        cfg_div = 16'd4; cfg_stop2 = 1'b0; cfg_parity = 2'd0;
        tx_data = 8'h00; tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        tn = 2;
        goto(12);
        check("t5_pre_txd",   32'(uart_txd),   32'd0);
        check("t5_pre_level", 32'(fifo_level), 32'd2);
        resetn = 1'b0;
        @(negedge clk);
        check("t5_rst_txd",   32'(uart_txd),     32'd1);
        check("t5_rst_level", 32'(fifo_level),   32'd0);
        check("t5_rst_busy",  32'(uart_tx_busy), 32'd0);
        resetn = 1'b1;
        repeat (60) @(negedge clk);
        check("t5_no_resume_txd", 32'(uart_txd), 32'd1);
        check("t5_no_resume_req", 32'(clk_req),  32'd0);

        // Divisor 0 clamps to 2.
        send_pin(8'hA5, 16'd0, 2, 2'd0, 1'b0, 12'b0000_1101_0010_10 >> 0, 10, "t6_div0");

        // Divisor change mid-frame applies only to the next frame.
        wait_idle();
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        tx_data = 8'h01; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        cfg_div = 16'd8;
        tn = 1;
        goto(5);
        check("t6_f1_start_end", 32'(uart_txd), 32'd0);
        goto(6);
        check("t6_f1_bit0",      32'(uart_txd), 32'd1);
        goto(42);
        check("t6_f2_start_lo",  32'(uart_txd), 32'd0);
        goto(49);
        check("t6_f2_start_hi",  32'(uart_txd), 32'd0);
        goto(50);
        check("t6_f2_bit0",      32'(uart_txd), 32'd1);
        goto(120);
        check("t6_busy_last",    32'(uart_tx_busy), 32'd1);
        goto(121);
        check("t6_busy_end",     32'(uart_tx_busy), 32'd0);

        wait_idle();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog at %0t: simulation did not complete", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
